// File: rtl/f_fetch_unit_if.sv
// Instruction-memory request/response channel used by the fetch stage.
// One outstanding request; responses arrive in order, one cycle each.
interface f_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, fetches from a variable-latency instruction memory and
// redirects on branches resolved in D, honouring one architectural delay slot.
module f_fetch_unit #(
    parameter logic [31:0] ResetPc = 32'h0000_3000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic [31:0]           d_pc_i,
    input  logic [2:0]            move_i,
    input  logic [2:0]            cmp_i,
    input  logic [25:0]           instr_index_i,
    input  logic [31:0]           ext_imm_i,
    input  logic [31:0]           cmp_rd1_i,
    f_fetch_unit_if.master        imem,
    output logic                  f_valid_o,
    output logic [31:0]           f_instr_o,
    output logic [31:0]           f_pc_o,
    output logic [31:0]           f_pc8_o
);

    typedef enum logic [2:0] {
        MoveSeq  = 3'd0,
        MoveBeq  = 3'd1,
        MoveBne  = 3'd2,
        MoveJump = 3'd3,
        MoveJr   = 3'd4
    } move_e;

    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        busy_q, busy_d;
    logic        squash_q, squash_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        taken;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic        issue;
    logic        accept;
    logic        resp;
    logic        consume;
    logic        kill_resp;
    logic        unused_cmp;

    assign unused_cmp = ^cmp_i[2:1];

    assign branch_tgt = d_pc_i + 32'd4 + (ext_imm_i << 2);
    assign jump_tgt   = {d_pc_i[31:28], instr_index_i, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = branch_tgt;
        case (move_i)
            MoveBeq:  taken = cmp_i[0];
            MoveBne:  taken = ~cmp_i[0];
            MoveJump: begin
                taken  = 1'b1;
                target = jump_tgt;
            end
            MoveJr:   begin
                taken  = 1'b1;
                target = cmp_rd1_i;
            end
            default:  taken = 1'b0;
        endcase
    end

    assign redirect = ~stall_i & taken;
    assign consume  = out_valid_q & ~stall_i;

    // Request only when the output slot will be free by the time the response lands.
    assign issue       = rst_ni & ~busy_q & (~out_valid_q | ~stall_i);
    assign imem.req    = issue;
    assign imem.addr   = {pc_q[31:2], 2'b00};
    assign accept      = issue & imem.ready;
    assign resp        = imem.rvalid & busy_q;

    // Delay slot leaves F now, so a response landing this cycle is past the slot.
    assign kill_resp = redirect & out_valid_q;

    always_comb begin
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        req_addr_d    = req_addr_q;
        busy_d        = busy_q;
        squash_d      = squash_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            busy_d     = 1'b1;
            req_addr_d = imem.addr;
            if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end

        if (resp) begin
            busy_d = 1'b0;
            if (squash_q || kill_resp) begin
                squash_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                out_instr_d = imem.rdata;
                out_pc_d    = req_addr_q;
            end
        end

        if (redirect) begin
            if (out_valid_q) begin
                pc_d = target;
                if (accept || (busy_q && !imem.rvalid)) begin
                    squash_d = 1'b1;
                end
            end else if (busy_q || accept) begin
                // The fetch in flight (or leaving now) is the delay slot.
                pc_d = target;
            end else begin
                pend_valid_d  = 1'b1;
                pend_target_d = target;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= ResetPc;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= ResetPc;
            req_addr_q    <= ResetPc;
            busy_q        <= 1'b0;
            squash_q      <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            req_addr_q    <= req_addr_d;
            busy_q        <= busy_d;
            squash_q      <= squash_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign f_valid_o = out_valid_q;
    assign f_instr_o = out_valid_q ? out_instr_q : 32'd0;
    assign f_pc_o    = out_pc_q;
    assign f_pc8_o   = out_pc_q + 32'd8;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: acts as memory and D stage, predicting the program-order
// stream of instructions reaching D from branch/delay-slot rules.
module tb_f_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] d_pc;
    logic [2:0]  move;
    logic [2:0]  cmp;
    logic [25:0] instr_index;
    logic [31:0] ext_imm;
    logic [31:0] cmp_rd1;
    logic        f_valid;
    logic [31:0] f_instr, f_pc, f_pc8;

    f_fetch_unit_if imem_bus ();

    f_fetch_unit #(.ResetPc(ResetPc)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .d_pc_i        (d_pc),
        .move_i        (move),
        .cmp_i         (cmp),
        .instr_index_i (instr_index),
        .ext_imm_i     (ext_imm),
        .cmp_rd1_i     (cmp_rd1),
        .imem          (imem_bus.master),
        .f_valid_o     (f_valid),
        .f_instr_o     (f_instr),
        .f_pc_o        (f_pc),
        .f_pc8_o       (f_pc8)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  move;
        logic [2:0]  cmp;
        logic [31:0] imm;
        logic [25:0] idx;
        logic [31:0] rd1;
        int          hold;
        int          nrdy;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[$];
    vec_t fv;

    int errors = 0;
    int checks = 0;
    int cyc;
    bit rand_mode;

    bit          mem_busy;
    int          mem_lat;
    logic [31:0] mem_addr;

    bit          d_valid;
    logic [31:0] d_pc_m;
    logic [2:0]  d_move_m, d_cmp_m;
    logic [31:0] d_imm_m, d_rd1_m;
    logic [25:0] d_idx_m;

    bit          slot_next;
    logic [31:0] exp_pc;
    bit          pend_m;
    logic [31:0] pend_tgt_m;

    logic [31:0] force_pc;
    int          hold_cnt, nrdy_cnt;
    bit          nrdy_started, stall_force, mon_stall, inject_stale;

    logic [31:0] cons_q[$];
    int          cons_cyc[$];
    logic [31:0] acc_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h2402_0001 ^ ((a ^ 32'h0000_3000) << 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        mem_busy = 0; mem_lat = 0; mem_addr = '0;
        d_valid = 0; d_pc_m = '0; d_move_m = '0; d_cmp_m = '0;
        d_imm_m = '0; d_rd1_m = '0; d_idx_m = '0;
        slot_next = 0; exp_pc = ResetPc; pend_m = 0; pend_tgt_m = '0;
        hold_cnt = 0; nrdy_cnt = 0; nrdy_started = 0;
        stall_force = 0; mon_stall = 0; inject_stale = 0;
        cons_q.delete(); cons_cyc.delete(); acc_q.delete();
        cyc = 0;
    endtask

    task automatic new_d_kind();
        int v;
        int k;
        v = int'($urandom_range(0, 63)) - 32;
        d_cmp_m = 3'($urandom);
        d_imm_m = v;
        d_idx_m = 26'(32'h0C00 + $urandom_range(0, 1023));
        d_rd1_m = 32'h3000 + ($urandom_range(0, 1023) << 2);
        if (rand_mode) begin
            if (slot_next || $urandom_range(0, 9) >= 3) begin
                k = int'($urandom_range(0, 3));
                d_move_m = (k == 0) ? 3'd0 : 3'(k + 4);
            end else begin
                d_move_m = 3'($urandom_range(1, 4));
            end
        end else if (d_pc_m == force_pc) begin
            d_move_m = fv.move; d_cmp_m = fv.cmp; d_imm_m = fv.imm;
            d_idx_m = fv.idx; d_rd1_m = fv.rd1; hold_cnt = fv.hold;
        end else begin
            d_move_m = 3'd0;
        end
        slot_next = (d_move_m >= 3'd1 && d_move_m <= 3'd4);
    endtask

    task automatic drive_inputs();
        stall = rand_mode ? ($urandom_range(0, 3) == 0) : (stall_force || hold_cnt > 0);
        if (hold_cnt > 0) hold_cnt--;
        d_pc = d_pc_m;
        move = d_valid ? d_move_m : 3'd0;
        cmp = d_cmp_m; instr_index = d_idx_m; ext_imm = d_imm_m; cmp_rd1 = d_rd1_m;
        if (rand_mode) begin
            imem_bus.ready = ($urandom_range(0, 9) < 7);
        end else begin
            if (!nrdy_started && f_valid && f_pc == force_pc) begin
                nrdy_started = 1;
                nrdy_cnt = fv.nrdy;
            end
            imem_bus.ready = (nrdy_cnt == 0);
            if (nrdy_cnt > 0) nrdy_cnt--;
        end
        if (inject_stale) begin
            imem_bus.rvalid = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
        end else if (mem_busy && mem_lat == 1) begin
            imem_bus.rvalid = 1'b1; imem_bus.rdata = instr_of(mem_addr);
        end else begin
            imem_bus.rvalid = 1'b0; imem_bus.rdata = $urandom;
        end
    endtask

    task automatic sample_update();
        bit acc, rv, tk;
        logic [31:0] tgt;
        acc = imem_bus.req && imem_bus.ready;
        rv  = imem_bus.rvalid && mem_busy && !inject_stale;
        if (!f_valid) check("bubble_instr", f_instr, 32'd0);
        if (mon_stall) begin
            check("stall_valid", f_valid, 1);
            check("stall_pc", f_pc, exp_pc);
            check("stall_instr", f_instr, instr_of(exp_pc));
            check("stall_no_accept", acc, 0);
        end
        if (acc) begin
            check("one_outstanding", mem_busy, 0);
            acc_q.push_back(imem_bus.addr);
        end
        if (rv) mem_busy = 0;
        else if (mem_busy) mem_lat--;
        if (acc) begin
            mem_busy = 1;
            mem_addr = imem_bus.addr;
            mem_lat  = rand_mode ? int'($urandom_range(1, 3)) : 1;
        end
        inject_stale = 0;
        if (!stall && d_valid) begin
            tk = 0; tgt = '0;
            case (d_move_m)
                3'd1: begin tk = d_cmp_m[0];  tgt = d_pc_m + 4 + d_imm_m * 4; end
                3'd2: begin tk = !d_cmp_m[0]; tgt = d_pc_m + 4 + d_imm_m * 4; end
                3'd3: begin tk = 1; tgt = (d_pc_m & 32'hF000_0000) | ({6'd0, d_idx_m} * 4); end
                3'd4: begin tk = 1; tgt = d_rd1_m; end
                default: tk = 0;
            endcase
            if (tk) begin
                pend_m = 1;
                pend_tgt_m = tgt;
            end
            d_valid = 0;
        end
        if (!stall && f_valid) begin
            check("cons_pc", f_pc, exp_pc);
            check("cons_instr", f_instr, instr_of(exp_pc));
            check("cons_pc8", f_pc8, exp_pc + 8);
            cons_q.push_back(f_pc);
            cons_cyc.push_back(cyc);
            d_valid = 1;
            d_pc_m = exp_pc;
            exp_pc = pend_m ? pend_tgt_m : exp_pc + 4;
            pend_m = 0;
            new_d_kind();
        end
        cyc++;
    endtask

    task automatic step();
        drive_inputs();
        @(negedge clk);
        sample_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        stall = 0; move = 0; cmp = 0; d_pc = 0; instr_index = 0; ext_imm = 0; cmp_rd1 = 0;
        imem_bus.ready = 0; imem_bus.rvalid = 0; imem_bus.rdata = 0;
        @(negedge clk);
        check("rst_req", imem_bus.req, 0);
        check("rst_valid", f_valid, 0);
        check("rst_instr", f_instr, 32'd0);
        check("rst_pc", f_pc, ResetPc);
        check("rst_pc8", f_pc8, ResetPc + 8);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        vecs.push_back('{"beq_taken_slotF", 3'd1, 3'b001, 32'd4, 26'd0, 32'd0, 2, 0, 32'h300C, 32'h301C});
        vecs.push_back('{"bne_not_taken", 3'd2, 3'b001, 32'd4, 26'd0, 32'd0, 0, 0, 32'h300C, 32'h3010});
        vecs.push_back('{"bne_taken_back", 3'd2, 3'b000, 32'hFFFF_FFFE, 26'd0, 32'd0, 0, 0, 32'h300C, 32'h3004});
        vecs.push_back('{"beq_not_taken", 3'd1, 3'b110, 32'd4, 26'd0, 32'd0, 2, 0, 32'h300C, 32'h3010});
        vecs.push_back('{"j_inflight", 3'd3, 3'b000, 32'd0, 26'h0C40, 32'd0, 0, 0, 32'h300C, 32'h3100});
        vecs.push_back('{"jr_pending", 3'd4, 3'b000, 32'd0, 26'd0, 32'h3100, 0, 2, 32'h300C, 32'h3100});
        vecs.push_back('{"jr_accept_same", 3'd4, 3'b000, 32'd0, 26'd0, 32'h3200, 0, 1, 32'h300C, 32'h3200});
        vecs.push_back('{"move5_seq", 3'd5, 3'b001, 32'd4, 26'h0C40, 32'h3100, 0, 0, 32'h300C, 32'h3010});
        vecs.push_back('{"move7_seq", 3'd7, 3'b000, 32'd4, 26'h0C40, 32'h3100, 2, 0, 32'h300C, 32'h3010});
        vecs.push_back('{"beq_zero_off", 3'd1, 3'b011, 32'd0, 26'd0, 32'd0, 2, 0, 32'h300C, 32'h300C});
        vecs.push_back('{"j_slotF", 3'd3, 3'b000, 32'd0, 26'h0C90, 32'd0, 2, 0, 32'h300C, 32'h3240});

        // Zero-wait memory: first request at once, one instruction every two cycles.
        rand_mode = 0;
        force_pc = 32'hFFFF_FFFF;
        do_reset();
        step();
        check("first_req_count", acc_q.size(), 1);
        if (acc_q.size() > 0) check("first_req_addr", acc_q[0], 32'h3000);
        repeat (7) step();
        check("cons_count", cons_q.size(), 3);
        if (cons_q.size() >= 2) begin
            check("first_cons_cycle", cons_cyc[0], 2);
            check("second_cons_cycle", cons_cyc[1], 4);
            check("first_cons_pc", cons_q[0], 32'h3000);
        end
        if (acc_q.size() >= 2) check("second_req_addr", acc_q[1], 32'h3004);

        // Five stalled cycles with a valid instruction held in F.
        n = 0;
        while (!f_valid && n < 10) begin
            step();
            n++;
        end
        check("stall_setup_valid", f_valid, 1);
        mon_stall = 1;
        stall_force = 1;
        repeat (5) step();
        mon_stall = 0;
        stall_force = 0;
        n = cons_q.size();
        repeat (6) step();
        check("resume_after_stall", cons_q.size() > n, 1);

        // Reset while a request is outstanding, stale response right after release.
        do_reset();
        step();
        do_reset();
        inject_stale = 1;
        step();
        check("stale_ignored", f_valid, 0);
        if (acc_q.size() > 0) check("restart_addr", acc_q[0], 32'h3000);
        repeat (4) step();
        check("restart_cons", cons_q.size() >= 1, 1);
        if (cons_q.size() >= 1) check("restart_pc", cons_q[0], 32'h3000);

        // Directed branch table: branch sits at 0x3008.
        foreach (vecs[i]) begin
            fv = vecs[i];
            force_pc = 32'h3008;
            rand_mode = 0;
            do_reset();
            n = 0;
            while (cons_q.size() < 5 && n < 80) begin
                step();
                n++;
            end
            if (cons_q.size() < 5) begin
                check({fv.name, "_timeout"}, cons_q.size(), 5);
            end else begin
                check({fv.name, "_branch"}, cons_q[2], 32'h3008);
                check({fv.name, "_slot"}, cons_q[3], fv.exp1);
                check({fv.name, "_next"}, cons_q[4], fv.exp2);
            end
        end

        // Random stalls, memory latency and branch mix against the program-order model.
        rand_mode = 1;
        force_pc = 32'hFFFF_FFFF;
        do_reset();
        repeat (4000) step();
        check("random_progress", cons_q.size() > 300, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
